alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

ALU reservation station and issue stage for the out-of-order core. It accepts renamed instructions from dispatch and tracks source-operand readiness by snooping the common data bus (CDB). Each cycle it selects the oldest ready entry and loads it into an issue register that directly drives the ALU execute unit (`line_to_execute`, `execute_valid_alu`, physical-register read tags). It also squashes wrong-path entries on branch recovery.

## Interface
Parameters:
- `RS_DEPTH`, default 8: number of entries; power of two, at least 2.
- `ROB_SIZE` and `NUM_PREGS` come from `rv32i_types`. `PW = $clog2(NUM_PREGS)`, `RW = $clog2(ROB_SIZE)`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `dispatch_valid` in 1: a new entry is presented.
- `dispatch_entry` in `reservation_station_entry_t`: decoded/renamed instruction.
- `dispatch_ps1`, `dispatch_ps2` in PW: physical source tags.
- `dispatch_ps1_rdy`, `dispatch_ps2_rdy` in 1: source already valid in the PRF (or unused).
- `rs_full` out 1: all slots occupied.
- `cdb` in `data_bus_package_t`: completed-result broadcast.
- `line_to_execute` out `reservation_station_entry_t`: issue register contents.
- `execute_valid_alu` out 1: the issue register holds a live instruction.
- `issue_ps1`, `issue_ps2` out PW: PRF read addresses for the issued entry.
- `branch_recovery` in 1: a mispredicted branch is resolving this cycle.
- `br_issue_ptr` in RW: ROB index of that branch.
- `rob_head` in RW: ROB index of the oldest in-flight instruction.

## Operation
**Slot state.** Each slot holds `valid`, the entry, `ps1`, `ps2`, `rdy1`, and `rdy2`.

**Wakeup.**
- A wakeup fires when `cdb.execute_valid & cdb.regf_we` is high and `cdb.phys_rd != 0`.
- Every valid slot whose `ps1` or `ps2` equals `cdb.phys_rd` sets the matching ready bit at the clock edge.
- Dispatch bypass: a dispatching source whose tag matches the CDB tag in the same cycle is written as ready.

**Dispatch.**
- When `dispatch_valid & ~rs_full`, the entry is written into the lowest-index free slot at the clock edge.
- When `rs_full` is high, `dispatch_valid` is ignored. Upstream must stall.

**Age and select.**
- Age of an entry = `(rob_index - rob_head) mod ROB_SIZE`, computed in RW bits so wrap-around is handled. Smaller means older.
- Select chooses the valid slot with `rdy1 & rdy2` and the smallest age.

**Issue register.**
- The issue register is a single stage and is unconditionally reloaded every cycle. The ALU never stalls.
- On each edge it loads the selected slot and frees that slot. `execute_valid_alu` goes to 1.
- If no slot is ready, `execute_valid_alu` goes to 0. `line_to_execute` holds its value but is a don't-care.

**Branch recovery.** Applied at the edge of any cycle in which `branch_recovery` is high:
- Let `B = (br_issue_ptr - rob_head) mod ROB_SIZE`.
- Every slot with age greater than B is invalidated.
- A dispatch presented in the same cycle is dropped.
- A selected candidate with age greater than B is not loaded. `execute_valid_alu` goes to 0 for that cycle, and the slot is invalidated like the others.
- Older entries are kept.
- Because selection reads only registered state, the branch output of the execute unit does not form a combinational loop.

**Simultaneous events.**
- Dispatch, wakeup, issue, and recovery may all occur in the same cycle; each affects different slots.
- A slot freed by issue in cycle N is not reusable by dispatch until cycle N+1, because `rs_full` is computed from current occupancy.

**Reset.** The next edge with `rst` high clears all slot `valid` bits and sets `execute_valid_alu=0`. This overrides any concurrent dispatch, issue, or recovery.

## Timing
- **Reset values:** `rs_full=0`, `execute_valid_alu=0`, `issue_ps1=0`, `issue_ps2=0`, `line_to_execute='0`.
- **Dispatch to issue:** an entry dispatched at edge N with both sources ready is selectable in cycle N and drives `execute_valid_alu` from edge N+1. Minimum latency is 2 edges from `dispatch_valid`.
- **Wakeup:** a CDB broadcast in cycle N makes the consumer ready at edge N. It is selectable in cycle N+1 and issued at edge N+2. The consumer must see the PRF value via combinational PRF read in its execute cycle.
- **Throughput:** one issue per cycle; one dispatch per cycle.
- **`rs_full`:** combinational from slot `valid` bits only.

## Structure
- Add to `rv32i_types`: `rs_slot_t` (valid, entry, ps1, ps2, rdy1, rdy2) and a `RS_DEPTH` default constant.
- Sub-module `oldest_ready_select`: a parameterised combinational priority select. It takes per-slot ready/age vectors and returns a grant index and a grant-valid flag. Ties cannot occur, because ROB indices are unique.
- The top module holds the slot array, wakeup compare, dispatch free-slot finder, recovery compare, and the issue register.

## Test plan
- **Basic issue:** reset, then dispatch an ADD with both sources ready and `rob_index=3`, `rob_head=0`. Require `execute_valid_alu=1` two edges after dispatch, with `line_to_execute.rob_index=3`, and `rs_full` never asserting.
- **Wakeup:** dispatch an entry with `ps1=12` and `rdy1=0`. Broadcast `cdb.phys_rd=12` (`regf_we=1`) two cycles later. Require the entry to issue at the second edge after the broadcast. Also require that a broadcast to `phys_rd=0` never wakes a slot.
- **Age with wrap:** set `rob_head=14` (`ROB_SIZE=16`), then make ready entries with rob indices 1, 15, and 14 together. Require issue order 14, 15, 1 on consecutive cycles.
- **Full:** fill 8 entries with unready sources and assert `dispatch_valid` with a ninth. Require `rs_full=1` and the ninth entry never to issue. Then wake one slot and issue it; require `rs_full=0` on the following cycle.
- **Recovery:** set `rob_head=0` with slots at rob indices 2, 5, 9, all ready, plus a concurrent dispatch with index 10. Pulse `branch_recovery` with `br_issue_ptr=4`. Require only index 2 to issue afterward, with 5, 9, and 10 never issuing.
- **Reset mid-operation:** with 4 slots occupied and `execute_valid_alu=1`, assert `rst` for one cycle. Require `execute_valid_alu=0` and all slots empty, with no stale issue after `rst` is released.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core types: renamed-instruction payload, CDB broadcast and ALU reservation-station slot.
package rv32i_types;

  localparam int ROB_SIZE         = 16;
  localparam int NUM_PREGS        = 64;
  localparam int PW               = $clog2(NUM_PREGS);
  localparam int RW               = $clog2(ROB_SIZE);
  localparam int RS_DEPTH_DEFAULT = 8;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef struct packed {
    alu_op_t         alu_op;
    logic            use_imm;
    logic [31:0]     imm;
    logic [31:0]     pc;
    logic [PW-1:0]   pd;
    logic [RW-1:0]   rob_index;
  } reservation_station_entry_t;

  typedef struct packed {
    logic            execute_valid;
    logic            regf_we;
    logic [PW-1:0]   phys_rd;
    logic [31:0]     rd_data;
    logic [RW-1:0]   rob_index;
  } data_bus_package_t;

  typedef struct packed {
    logic                        valid;
    reservation_station_entry_t  entry;
    logic [PW-1:0]               ps1;
    logic [PW-1:0]               ps2;
    logic                        rdy1;
    logic                        rdy2;
  } rs_slot_t;

  // Distance from the ROB head; modulo arithmetic keeps ordering correct across wrap.
  function automatic logic [RW-1:0] rob_age(input logic [RW-1:0] idx, input logic [RW-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/oldest_ready_select.sv
// Combinational pick of the ready slot with the smallest age; zero latency, no backpressure.
module oldest_ready_select #(
  parameter int N  = 8,
  parameter int AW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]         rdy_i,
  input  logic [N-1:0][AW-1:0] age_i,
  output logic [IW-1:0]        gnt_idx_o,
  output logic                 gnt_vld_o
);

  logic [AW-1:0] best_age;

  always_comb begin
    best_age  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rdy_i[i] && (!gnt_vld_o || (age_i[i] < best_age))) begin
        gnt_vld_o = 1'b1;
        best_age  = age_i[i];
        gnt_idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station + single-stage issue register; dispatch-to-issue 2 edges, CDB wakeup-to-issue 2 edges.
// Dispatch stalls via rs_full (combinational from occupancy); the issue side never stalls.
module alu_issue_queue
  import rv32i_types::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dispatch_valid,
  input  reservation_station_entry_t  dispatch_entry,
  input  logic [PW-1:0]               dispatch_ps1,
  input  logic [PW-1:0]               dispatch_ps2,
  input  logic                        dispatch_ps1_rdy,
  input  logic                        dispatch_ps2_rdy,
  output logic                        rs_full,
  input  data_bus_package_t           cdb,
  output reservation_station_entry_t  line_to_execute,
  output logic                        execute_valid_alu,
  output logic [PW-1:0]               issue_ps1,
  output logic [PW-1:0]               issue_ps2,
  input  logic                        branch_recovery,
  input  logic [RW-1:0]               br_issue_ptr,
  input  logic [RW-1:0]               rob_head
);

  localparam int IW = $clog2(RS_DEPTH);

  rs_slot_t                    slots_q [RS_DEPTH];
  rs_slot_t                    slots_d [RS_DEPTH];
  reservation_station_entry_t  line_q, line_d;
  logic                        vld_q, vld_d;
  logic [PW-1:0]               ps1_q, ps1_d, ps2_q, ps2_d;

  logic [RS_DEPTH-1:0]         valid_vec, rdy_vec;
  logic [RS_DEPTH-1:0][RW-1:0] age_vec;
  logic [IW-1:0]               free_idx, gnt_idx;
  logic                        gnt_vld, squash_gnt, wake;
  logic [RW-1:0]               br_age;
  rs_slot_t                    new_slot;
  logic                        unused_cdb;

  assign unused_cdb = ^{cdb.rd_data, cdb.rob_index};

  assign wake    = cdb.execute_valid & cdb.regf_we & (cdb.phys_rd != '0);
  assign br_age  = rob_age(br_issue_ptr, rob_head);
  assign rs_full = &valid_vec;

  always_comb begin
    valid_vec = '0;
    rdy_vec   = '0;
    age_vec   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid_vec[i] = slots_q[i].valid;
      rdy_vec[i]   = slots_q[i].valid & slots_q[i].rdy1 & slots_q[i].rdy2;
      age_vec[i]   = rob_age(slots_q[i].entry.rob_index, rob_head);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IW'(i);
    end
  end

  oldest_ready_select #(
    .N  (RS_DEPTH),
    .AW (RW),
    .IW (IW)
  ) u_select (
    .rdy_i     (rdy_vec),
    .age_i     (age_vec),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // A source matching this cycle's broadcast is captured as ready on the way in.
  always_comb begin
    new_slot       = '0;
    new_slot.valid = 1'b1;
    new_slot.entry = dispatch_entry;
    new_slot.ps1   = dispatch_ps1;
    new_slot.ps2   = dispatch_ps2;
    new_slot.rdy1  = dispatch_ps1_rdy | (wake && (dispatch_ps1 == cdb.phys_rd));
    new_slot.rdy2  = dispatch_ps2_rdy | (wake && (dispatch_ps2 == cdb.phys_rd));
  end

  assign squash_gnt = branch_recovery && (age_vec[gnt_idx] > br_age);

  always_comb begin
    slots_d = slots_q;
    line_d  = line_q;
    ps1_d   = ps1_q;
    ps2_d   = ps2_q;
    vld_d   = gnt_vld & ~squash_gnt;

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (wake && slots_q[i].valid) begin
        if (slots_q[i].ps1 == cdb.phys_rd) slots_d[i].rdy1 = 1'b1;
        if (slots_q[i].ps2 == cdb.phys_rd) slots_d[i].rdy2 = 1'b1;
      end
    end

    if (gnt_vld) begin
      slots_d[gnt_idx].valid = 1'b0;
      if (!squash_gnt) begin
        line_d = slots_q[gnt_idx].entry;
        ps1_d  = slots_q[gnt_idx].ps1;
        ps2_d  = slots_q[gnt_idx].ps2;
      end
    end

    if (branch_recovery) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (age_vec[i] > br_age) slots_d[i].valid = 1'b0;
      end
    end

    // The free slot is never the granted one, so dispatch cannot collide with issue.
    if (dispatch_valid && !rs_full && !branch_recovery) begin
      slots_d[free_idx] = new_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) slots_q[i] <= '0;
      line_q <= '0;
      vld_q  <= 1'b0;
      ps1_q  <= '0;
      ps2_q  <= '0;
    end else begin
      slots_q <= slots_d;
      line_q  <= line_d;
      vld_q   <= vld_d;
      ps1_q   <= ps1_d;
      ps2_q   <= ps2_d;
    end
  end

  assign line_to_execute   = line_q;
  assign execute_valid_alu = vld_q;
  assign issue_ps1         = ps1_q;
  assign issue_ps2         = ps2_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboarded bench for alu_issue_queue: every issue is matched against a queue of expected issues.
module tb_alu_issue_queue;
  import rv32i_types::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        dispatch_valid;
  reservation_station_entry_t  dispatch_entry;
  logic [PW-1:0]               dispatch_ps1, dispatch_ps2;
  logic                        dispatch_ps1_rdy, dispatch_ps2_rdy;
  logic                        rs_full;
  data_bus_package_t           cdb;
  reservation_station_entry_t  line_to_execute;
  logic                        execute_valid_alu;
  logic [PW-1:0]               issue_ps1, issue_ps2;
  logic                        branch_recovery;
  logic [RW-1:0]               br_issue_ptr, rob_head;

  always #5 clk = ~clk;

  alu_issue_queue #(.RS_DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .dispatch_valid    (dispatch_valid),
    .dispatch_entry    (dispatch_entry),
    .dispatch_ps1      (dispatch_ps1),
    .dispatch_ps2      (dispatch_ps2),
    .dispatch_ps1_rdy  (dispatch_ps1_rdy),
    .dispatch_ps2_rdy  (dispatch_ps2_rdy),
    .rs_full           (rs_full),
    .cdb               (cdb),
    .line_to_execute   (line_to_execute),
    .execute_valid_alu (execute_valid_alu),
    .issue_ps1         (issue_ps1),
    .issue_ps2         (issue_ps2),
    .branch_recovery   (branch_recovery),
    .br_issue_ptr      (br_issue_ptr),
    .rob_head          (rob_head)
  );

  typedef struct {
    logic [RW-1:0] rob;
    logic [PW-1:0] ps1;
    logic [PW-1:0] ps2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  always @(negedge clk) begin
    if (execute_valid_alu === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_issue: got rob %0d, required no issue", line_to_execute.rob_index);
      end else begin
        mon_e = sb.pop_front();
        if (line_to_execute.rob_index !== mon_e.rob || issue_ps1 !== mon_e.ps1 || issue_ps2 !== mon_e.ps2) begin
          mismatched++;
          $display("FAIL issue_order: got rob %0d ps1 %0d ps2 %0d, required rob %0d ps1 %0d ps2 %0d",
                   line_to_execute.rob_index, issue_ps1, issue_ps2, mon_e.rob, mon_e.ps1, mon_e.ps2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid   = 1'b0;
    dispatch_entry   = '0;
    dispatch_ps1     = '0;
    dispatch_ps2     = '0;
    dispatch_ps1_rdy = 1'b0;
    dispatch_ps2_rdy = 1'b0;
    cdb              = '0;
    branch_recovery  = 1'b0;
    br_issue_ptr     = '0;
  endtask

  task automatic set_disp(input logic [RW-1:0] rob, input logic [PW-1:0] p1, input logic r1,
                          input logic [PW-1:0] p2, input logic r2);
    dispatch_valid           = 1'b1;
    dispatch_entry           = '0;
    dispatch_entry.alu_op    = ALU_ADD;
    dispatch_entry.pc        = 32'h1000 + 32'(rob) * 4;
    dispatch_entry.pd        = PW'(rob) + PW'(32);
    dispatch_entry.rob_index = rob;
    dispatch_ps1             = p1;
    dispatch_ps2             = p2;
    dispatch_ps1_rdy         = r1;
    dispatch_ps2_rdy         = r2;
  endtask

  task automatic set_cdb(input logic [PW-1:0] tag, input logic we);
    cdb               = '0;
    cdb.execute_valid = 1'b1;
    cdb.regf_we       = we;
    cdb.phys_rd       = tag;
    cdb.rd_data       = 32'hCAFE_0000 | 32'(tag);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rob_head = '0;
    rst = 1'b1;
    set_disp(RW'(1), PW'(1), 1'b1, PW'(2), 1'b1);
    step();
    step();
    rst = 1'b0;
    idle();
    compared++;
    if (rs_full !== 1'b0) begin mismatched++; $display("FAIL reset_rs_full: got %b, required 0", rs_full); end
    compared++;
    if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b, required 0", execute_valid_alu); end
    compared++;
    if (issue_ps1 !== '0 || issue_ps2 !== '0) begin
      mismatched++; $display("FAIL reset_issue_ps: got %0d/%0d, required 0/0", issue_ps1, issue_ps2);
    end
    compared++;
    if (line_to_execute !== '0) begin mismatched++; $display("FAIL reset_line: got %h, required 0", line_to_execute); end
  endtask

  task automatic test_basic_issue();
    apply_reset();
    rob_head = '0;
    set_disp(RW'(3), PW'(5), 1'b1, PW'(6), 1'b1);
    sb.push_back('{RW'(3), PW'(5), PW'(6)});
    step();
    idle();
    compared++;
    if (execute_valid_alu !== 1'b0 || rs_full !== 1'b0) begin
      mismatched++; $display("FAIL basic_edge1: got valid %b full %b, required 0 0", execute_valid_alu, rs_full);
    end
    step();
    compared++;
    if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== RW'(3) || rs_full !== 1'b0) begin
      mismatched++; $display("FAIL basic_edge2: got valid %b rob %0d full %b, required 1 3 0",
                             execute_valid_alu, line_to_execute.rob_index, rs_full);
    end
    step();
    compared++;
    if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL basic_single: got valid %b, required 0", execute_valid_alu); end
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_wakeup();
    apply_reset();
    rob_head = '0;
    set_disp(RW'(5), PW'(12), 1'b0, PW'(7), 1'b1);
    step();
    set_disp(RW'(6), PW'(3), 1'b1, PW'(0), 1'b0);
    step();
    idle();
    step();
    set_cdb(PW'(0), 1'b1);
    step();
    set_cdb(PW'(12), 1'b0);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      compared++;
      if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL wake_false: got valid %b, required 0", execute_valid_alu); end
    end
    set_cdb(PW'(12), 1'b1);
    sb.push_back('{RW'(5), PW'(12), PW'(7)});
    step();
    idle();
    compared++;
    if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL wake_edge1: got valid %b, required 0", execute_valid_alu); end
    step();
    compared++;
    if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== RW'(5)) begin
      mismatched++; $display("FAIL wake_edge2: got valid %b rob %0d, required 1 5", execute_valid_alu, line_to_execute.rob_index);
    end
    set_disp(RW'(7), PW'(30), 1'b0, PW'(31), 1'b1);
    set_cdb(PW'(30), 1'b1);
    sb.push_back('{RW'(7), PW'(30), PW'(31)});
    step();
    idle();
    compared++;
    if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL bypass_edge1: got valid %b, required 0", execute_valid_alu); end
    step();
    compared++;
    if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== RW'(7)) begin
      mismatched++; $display("FAIL bypass_edge2: got valid %b rob %0d, required 1 7", execute_valid_alu, line_to_execute.rob_index);
    end
    step();
    step();
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL wake_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_age_wrap();
    logic [RW-1:0] order [3];
    order[0] = RW'(14);
    order[1] = RW'(15);
    order[2] = RW'(1);
    apply_reset();
    rob_head = RW'(14);
    set_disp(RW'(1), PW'(40), 1'b0, PW'(41), 1'b1);
    step();
    set_disp(RW'(15), PW'(40), 1'b0, PW'(41), 1'b1);
    step();
    set_disp(RW'(14), PW'(40), 1'b0, PW'(41), 1'b1);
    step();
    idle();
    set_cdb(PW'(40), 1'b1);
    for (int i = 0; i < 3; i++) sb.push_back('{order[i], PW'(40), PW'(41)});
    step();
    idle();
    compared++;
    if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL age_edge1: got valid %b, required 0", execute_valid_alu); end
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== order[i]) begin
        mismatched++; $display("FAIL age_order%0d: got valid %b rob %0d, required 1 %0d",
                               i, execute_valid_alu, line_to_execute.rob_index, order[i]);
      end
    end
    step();
    compared++;
    if (execute_valid_alu !== 1'b0 || sb.size() != 0) begin
      mismatched++; $display("FAIL age_drain: got valid %b pending %0d, required 0 0", execute_valid_alu, sb.size());
    end
  endtask

  task automatic test_full();
    apply_reset();
    rob_head = '0;
    for (int i = 0; i < 8; i++) begin
      set_disp(RW'(i), PW'(50 + i), 1'b0, PW'(2), 1'b1);
      compared++;
      if (rs_full !== 1'b0) begin mismatched++; $display("FAIL full_early%0d: got %b, required 0", i, rs_full); end
      step();
    end
    set_disp(RW'(8), PW'(4), 1'b1, PW'(5), 1'b1);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (rs_full !== 1'b1 || execute_valid_alu !== 1'b0) begin
        mismatched++; $display("FAIL full_hold%0d: got full %b valid %b, required 1 0", i, rs_full, execute_valid_alu);
      end
      step();
    end
    idle();
    set_cdb(PW'(53), 1'b1);
    sb.push_back('{RW'(3), PW'(53), PW'(2)});
    step();
    idle();
    compared++;
    if (rs_full !== 1'b1 || execute_valid_alu !== 1'b0) begin
      mismatched++; $display("FAIL full_wake: got full %b valid %b, required 1 0", rs_full, execute_valid_alu);
    end
    step();
    compared++;
    if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== RW'(3) || rs_full !== 1'b0) begin
      mismatched++; $display("FAIL full_free: got valid %b rob %0d full %b, required 1 3 0",
                             execute_valid_alu, line_to_execute.rob_index, rs_full);
    end
    step();
    step();
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL full_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_recovery();
    apply_reset();
    rob_head = '0;
    set_disp(RW'(1), PW'(45), 1'b0, PW'(61), 1'b1);
    step();
    set_disp(RW'(2), PW'(60), 1'b0, PW'(61), 1'b1);
    step();
    set_disp(RW'(5), PW'(60), 1'b0, PW'(61), 1'b1);
    step();
    set_disp(RW'(9), PW'(60), 1'b0, PW'(61), 1'b1);
    step();
    idle();
    set_cdb(PW'(60), 1'b1);
    step();
    idle();
    branch_recovery = 1'b1;
    br_issue_ptr    = RW'(4);
    set_disp(RW'(10), PW'(62), 1'b1, PW'(63), 1'b1);
    sb.push_back('{RW'(2), PW'(60), PW'(61)});
    step();
    idle();
    compared++;
    if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== RW'(2)) begin
      mismatched++; $display("FAIL recov_keep: got valid %b rob %0d, required 1 2", execute_valid_alu, line_to_execute.rob_index);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      compared++;
      if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL recov_squash%0d: got valid %b, required 0", i, execute_valid_alu); end
    end
    set_cdb(PW'(45), 1'b1);
    sb.push_back('{RW'(1), PW'(45), PW'(61)});
    step();
    idle();
    step();
    compared++;
    if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== RW'(1)) begin
      mismatched++; $display("FAIL recov_older: got valid %b rob %0d, required 1 1", execute_valid_alu, line_to_execute.rob_index);
    end
    set_disp(RW'(6), PW'(44), 1'b0, PW'(61), 1'b1);
    step();
    set_disp(RW'(9), PW'(44), 1'b0, PW'(61), 1'b1);
    step();
    idle();
    set_cdb(PW'(44), 1'b1);
    step();
    idle();
    branch_recovery = 1'b1;
    br_issue_ptr    = RW'(4);
    step();
    idle();
    compared++;
    if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL recov_cand: got valid %b, required 0", execute_valid_alu); end
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (execute_valid_alu !== 1'b0 || rs_full !== 1'b0) begin
        mismatched++; $display("FAIL recov_after%0d: got valid %b full %b, required 0 0", i, execute_valid_alu, rs_full);
      end
    end
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL recov_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rob_head = '0;
    for (int i = 0; i < 5; i++) begin
      set_disp(RW'(i), PW'(20), 1'b0, PW'(21), 1'b1);
      step();
    end
    idle();
    set_cdb(PW'(20), 1'b1);
    sb.push_back('{RW'(0), PW'(20), PW'(21)});
    step();
    idle();
    step();
    compared++;
    if (execute_valid_alu !== 1'b1 || line_to_execute.rob_index !== RW'(0)) begin
      mismatched++; $display("FAIL mid_pre: got valid %b rob %0d, required 1 0", execute_valid_alu, line_to_execute.rob_index);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    compared++;
    if (execute_valid_alu !== 1'b0 || rs_full !== 1'b0) begin
      mismatched++; $display("FAIL mid_rst: got valid %b full %b, required 0 0", execute_valid_alu, rs_full);
    end
    set_cdb(PW'(20), 1'b1);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (execute_valid_alu !== 1'b0) begin mismatched++; $display("FAIL mid_stale%0d: got valid %b, required 0", i, execute_valid_alu); end
    end
    for (int i = 0; i < 8; i++) begin
      set_disp(RW'(8 + i), PW'(22), 1'b0, PW'(23), 1'b1);
      step();
      compared++;
      if (rs_full !== ((i == 7) ? 1'b1 : 1'b0)) begin
        mismatched++; $display("FAIL mid_empty%0d: got full %b, required %b", i, rs_full, (i == 7));
      end
    end
    idle();
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL mid_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    rst      = 1'b1;
    rob_head = '0;
    idle();
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_age_wrap();
    test_full();
    test_recovery();
    test_reset_mid();
    apply_reset();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
